// File: rtl/trade_report_scheduler.sv
// trade_report_scheduler: queues trades, injects heartbeats, and frames them as 6-byte reports on a valid/ready byte link
module trade_report_scheduler #(
  parameter int DEPTH = 8,
  parameter int HB_PERIOD = 1000
) (
  input  logic                      low_clk,
  input  logic                      rst,
  input  logic                      trade_valid,
  input  logic                      trade_side,
  input  logic [31:0]               balance,
  input  logic                      tx_ready,
  output logic                      tx_valid,
  output logic [7:0]                tx_data,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow,
  output logic [15:0]               drop_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [32:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic overflow_q, overflow_d, hb_pend_q, hb_pend_d;
  logic [15:0] drop_q, drop_d;
  logic [31:0] hb_cnt_q, hb_cnt_d;
  logic [47:0] sr_q, sr_d;
  logic [2:0] idx_q, idx_d;
  logic [32:0] head;
  logic pop, wr, drop, load_hb, accept, last, hb_wrap;

  function automatic logic [47:0] frame(input logic [7:0] h, input logic [31:0] b);
    return {h, b, h ^ b[31:24] ^ b[23:16] ^ b[15:8] ^ b[7:0]};
  endfunction

  // Handshake qualifiers: an idle FSM pops a non-empty FIFO before it considers a heartbeat
  always_comb begin
    head    = mem_q[rd_ptr_q];
    pop     = state_q == IDLE && cnt_q != '0;
    load_hb = state_q == IDLE && cnt_q == '0 && hb_pend_q;
    wr      = trade_valid && (cnt_q != (AW+1)'(DEPTH) || pop);
    drop    = trade_valid && !wr;
    accept  = state_q == SEND && tx_ready;
    last    = accept && idx_q == 3'd5;
    hb_wrap = HB_PERIOD != 0 && hb_cnt_q == 32'(HB_PERIOD - 1);
  end

  // FIFO bookkeeping, drop statistics, heartbeat timer and the frame shift register
  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(wr);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    cnt_d      = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    overflow_d = overflow_q | drop;
    drop_d     = drop_q + 16'(drop && drop_q != 16'hFFFF);
    hb_cnt_d   = (HB_PERIOD == 0 || hb_wrap) ? 32'd0 : hb_cnt_q + 32'd1;
    hb_pend_d  = load_hb ? 1'b0 : (hb_pend_q | hb_wrap);
    sr_d       = pop ? frame(8'hA0 | {7'd0, head[32]}, head[31:0]) :
                 load_hb ? frame(8'hA2, balance) :
                 accept ? {sr_q[39:0], 8'h00} : sr_q;
    idx_d      = (pop || load_hb) ? 3'd0 : accept ? idx_q + 3'd1 : idx_q;
  end

  // Next state: leave IDLE whenever there is work, return after B5 is accepted
  always_comb begin
    state_d = state_q == IDLE ? ((cnt_q != '0 || hb_pend_q) ? SEND : IDLE) : (last ? IDLE : SEND);
  end

  // Outputs: the shift register drains to zero, so tx_data reads 0 between frames
  always_comb begin
    tx_valid   = state_q == SEND;
    busy       = state_q == SEND;
    tx_data    = sr_q[47:40];
    fifo_count = cnt_q;
    overflow   = overflow_q;
    drop_count = drop_q;
  end

  // State and control registers
  always_ff @(posedge low_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      hb_cnt_q   <= '0;
      hb_pend_q  <= 1'b0;
      sr_q       <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_pend_q  <= hb_pend_d;
      sr_q       <= sr_d;
      idx_q      <= idx_d;
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid
  always_ff @(posedge low_clk) begin
    if (!rst && wr) mem_q[wr_ptr_q] <= {trade_side, balance};
  end
endmodule
